cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among FU_NUM functional units. Each FU gets a one-entry holding register so it can hand off a result and retire it without waiting for the bus. One winner per cycle is broadcast as a registered {valid, data, reorder-buffer index, source} record. The block sits between the FU result ports and the CDB data controller / reorder buffer, and supports backpressure from the reorder buffer and a flush on misprediction.

## Interface
- FU_NUM, 4: number of requesting functional units (≥2).
- WORD_SIZE, 32: result width.
- RB_INDEX, 4: reorder-buffer index width; all-ones value is NULL.
- SRC_W, 2: width of the source id, equal to ceil(log2(FU_NUM)).
- clk  in  1: clock; all state updates on the rising edge.
- reset  in  1: asynchronous, active-high; clears all state immediately.
- fu_req  in  FU_NUM: per-FU result request.
- fu_data_bus  in  WORD_SIZE*FU_NUM: FU i result in bits [i*WORD_SIZE +: WORD_SIZE].
- fu_index_bus  in  RB_INDEX*FU_NUM: FU i destination RB index, same packing.
- rb_ready  in  1: the reorder buffer can accept a broadcast this cycle.
- flush  in  1: discard all held and pending results.
- fu_ack  out  FU_NUM: combinational; the request was captured at this edge.
- cdb_valid  out  1: registered broadcast valid, one cycle per result.
- cdb_data  out  WORD_SIZE: registered broadcast data.
- cdb_index  out  RB_INDEX: registered broadcast RB index.
- cdb_src  out  SRC_W: registered id of the winning FU.
- pending  out  SRC_W+1: registered count of full holding registers.

## Operation
- State:
  - hold_v[i], hold_data[i], hold_idx[i] for each FU.
  - last_grant pointer, SRC_W bits.
  - CDB output registers.
  - pending counter.
- Valid request: fu_req[i]=1 and fu_index_bus slice ≠ NULL. A NULL-index request is ignored: no ack, nothing is stored.
- Grant (combinational):
  - When rb_ready=1 and flush=0, the winner is the first i with hold_v[i]=1, searching from last_grant+1 upward and wrapping modulo FU_NUM.
  - No grant when rb_ready=0 or flush=1.
- fu_ack[i] = valid request & !flush & (!hold_v[i] | granted[i]). A full register whose entry is granted this cycle accepts a new entry in the same cycle.
- At each edge:
  - Acked FU: hold loads the new data and index.
  - Granted FU with no new ack: hold_v clears.
  - On a grant: cdb_* loads the winner, cdb_valid<=1, last_grant<=winner.
  - With no grant: cdb_valid<=0; data, index and src hold their last values.
- pending <= popcount(hold_v) of the next state.
- flush at an edge:
  - All hold_v<=0, cdb_valid<=0, pending<=0.
  - last_grant is kept.
  - flush has priority over simultaneous requests and grants.
- Reset, including mid-operation:
  - hold_v=0, cdb_valid=0, cdb_data=0, cdb_index=0, cdb_src=0, pending=0.
  - last_grant=FU_NUM-1, so FU0 has first priority after reset.
  - fu_ack=0 while reset is high.
- Fairness: with rb_ready held at 1, any full hold is broadcast within FU_NUM cycles.

## Timing
- Request in cycle n with an empty hold: fu_ack high in cycle n; hold full from edge n; cdb_valid high in cycle n+2. Minimum latency is 2 cycles.
- A lone requester can stream one result per cycle: each cycle it is acked while its previous entry is granted.
- Throughput is at most one broadcast per cycle.
- cdb_valid is a one-cycle pulse per result. A result is never broadcast twice and never dropped unless flush occurs.
- rb_ready low in cycle n: no broadcast in cycle n+1. Holds keep their contents. FUs with full holds see fu_ack=0.
- fu_ack depends combinationally on fu_req, fu_index_bus, rb_ready and flush. It has no combinational path to the cdb_* outputs.

## Test plan
- Reset: assert reset mid-stream with all holds full. Required: cdb_valid=0, cdb_data=0, cdb_index=0, cdb_src=0, pending=0 and fu_ack=0 immediately (asynchronous). After release, the first grant goes to FU0.
- Single request: FU2 requests with data 0xDEADBEEF, index 5 in cycle 1. Required: fu_ack[2]=1 in cycle 1. In cycle 3: cdb_valid=1, cdb_data=0xDEADBEEF, cdb_index=5, cdb_src=2. In cycle 4: cdb_valid=0.
- Round-robin: FU0–FU3 request in the same cycle with indexes 1–4, then FU0 and FU1 request again immediately. Required:
  - cdb_src sequence 0,1,2,3 on consecutive cycles.
  - The second FU0 entry follows FU3.
  - pending counts 4,3,2,1 as the first four broadcasts drain.
- Backpressure: hold rb_ready=0 for 3 cycles with FU1 and FU3 full. Required: cdb_valid=0 and fu_ack[1]=fu_ack[3]=0 for those cycles. After release, cdb_src=1 then 3 with the original data.
- Flush: assert flush for one cycle with 3 holds full and a new request from FU0. Required: fu_ack=0 that cycle, pending=0 next cycle, no broadcast of any flushed entry.
- NULL index: FU1 requests with index 0xF. Required: no ack, no broadcast, pending unchanged.

Source files
------------

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//   Round-robin arbiter sharing the common data bus among FU_NUM functional
//   units. Each FU owns a one-entry holding register so it can retire a result
//   without waiting for the bus. One winner per cycle is broadcast as a
//   registered {valid, data, rob index, source} record.
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   fu_req        in   per-FU result request
//   fu_data_bus   in   FU i result at [i*WORD_SIZE +: WORD_SIZE]
//   fu_index_bus  in   FU i destination rob index at [i*RB_INDEX +: RB_INDEX]
//   rb_ready      in   reorder buffer accepts a broadcast this cycle
//   flush         in   discard all held and pending results
//   fu_ack        out  combinational: request captured at this edge
//   cdb_valid     out  registered broadcast valid (one-cycle pulse per result)
//   cdb_data      out  registered broadcast data
//   cdb_index     out  registered broadcast rob index
//   cdb_src       out  registered id of the winning FU
//   pending       out  registered count of full holding registers
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int FU_NUM    = 4,
  parameter int WORD_SIZE = 32,
  parameter int RB_INDEX  = 4,
  parameter int SRC_W     = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FU_NUM-1:0]             fu_req,
  input  logic [WORD_SIZE*FU_NUM-1:0]   fu_data_bus,
  input  logic [RB_INDEX*FU_NUM-1:0]    fu_index_bus,
  input  logic                          rb_ready,
  input  logic                          flush,
  output logic [FU_NUM-1:0]             fu_ack,
  output logic                          cdb_valid,
  output logic [WORD_SIZE-1:0]          cdb_data,
  output logic [RB_INDEX-1:0]           cdb_index,
  output logic [SRC_W-1:0]              cdb_src,
  output logic [SRC_W:0]                pending
);

  localparam logic [RB_INDEX-1:0] NULL_IDX = '1;

  logic [FU_NUM-1:0]    hold_v;
  logic [FU_NUM-1:0]    hold_v_nxt;
  logic [FU_NUM-1:0]    valid_req;
  logic [FU_NUM-1:0]    grant_vec;
  logic [FU_NUM-1:0]    ack;
  logic [WORD_SIZE-1:0] hold_data [FU_NUM];
  logic [RB_INDEX-1:0]  hold_idx  [FU_NUM];
  logic [SRC_W-1:0]     last_grant;
  logic [SRC_W-1:0]     winner;
  logic                 grant_any;
  logic [SRC_W:0]       pending_nxt;
  int                   cand;

  // A request carrying the NULL rob index is not a result and is ignored.
  always_comb begin
    valid_req = '0;
    for (int i = 0; i < FU_NUM; i++)
      valid_req[i] = fu_req[i] && (fu_index_bus[i*RB_INDEX +: RB_INDEX] != NULL_IDX);
  end

  // Round-robin search starting just after the previous winner, wrapping.
  always_comb begin
    grant_vec = '0;
    grant_any = 1'b0;
    winner    = '0;
    cand      = 0;
    if (rb_ready && !flush) begin
      for (int k = 1; k <= FU_NUM; k++) begin
        cand = (int'(last_grant) + k) % FU_NUM;
        if (!grant_any && hold_v[cand]) begin
          grant_any = 1'b1;
          winner    = SRC_W'(cand);
        end
      end
      if (grant_any)
        grant_vec[winner] = 1'b1;
    end
  end

  // A full register whose entry leaves on the bus this cycle can take a new one.
  always_comb begin
    ack = '0;
    for (int i = 0; i < FU_NUM; i++)
      ack[i] = valid_req[i] && !flush && !reset && (!hold_v[i] || grant_vec[i]);
  end

  assign fu_ack = ack;

  always_comb begin
    hold_v_nxt  = flush ? '0 : (ack | (hold_v & ~grant_vec));
    pending_nxt = '0;
    for (int i = 0; i < FU_NUM; i++)
      pending_nxt = pending_nxt + (SRC_W+1)'(hold_v_nxt[i]);
  end

  // Control and broadcast registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_v     <= '0;
      last_grant <= SRC_W'(FU_NUM - 1);
      cdb_valid  <= 1'b0;
      cdb_data   <= '0;
      cdb_index  <= '0;
      cdb_src    <= '0;
      pending    <= '0;
    end else begin
      hold_v    <= hold_v_nxt;
      pending   <= pending_nxt;
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_data   <= hold_data[winner];
        cdb_index  <= hold_idx[winner];
        cdb_src    <= winner;
        last_grant <= winner;
      end
    end
  end

  // Holding payload; qualified by hold_v so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FU_NUM; i++) begin
      if (ack[i]) begin
        hold_data[i] <= fu_data_bus[i*WORD_SIZE +: WORD_SIZE];
        hold_idx[i]  <= fu_index_bus[i*RB_INDEX +: RB_INDEX];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int FU_NUM    = 4;
  localparam int WORD_SIZE = 32;
  localparam int RB_INDEX  = 4;
  localparam int SRC_W     = 2;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [FU_NUM-1:0]           fu_req;
  logic [WORD_SIZE*FU_NUM-1:0] fu_data_bus;
  logic [RB_INDEX*FU_NUM-1:0]  fu_index_bus;
  logic                        rb_ready;
  logic                        flush;
  logic [FU_NUM-1:0]           fu_ack;
  logic                        cdb_valid;
  logic [WORD_SIZE-1:0]        cdb_data;
  logic [RB_INDEX-1:0]         cdb_index;
  logic [SRC_W-1:0]            cdb_src;
  logic [SRC_W:0]              pending;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.FU_NUM(FU_NUM), .WORD_SIZE(WORD_SIZE), .RB_INDEX(RB_INDEX), .SRC_W(SRC_W)) dut (
    .clk(clk), .reset(reset), .fu_req(fu_req), .fu_data_bus(fu_data_bus),
    .fu_index_bus(fu_index_bus), .rb_ready(rb_ready), .flush(flush), .fu_ack(fu_ack),
    .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_index(cdb_index),
    .cdb_src(cdb_src), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [31:0] d, input logic [3:0] ix);
    fu_data_bus[i*WORD_SIZE +: WORD_SIZE] = d;
    fu_index_bus[i*RB_INDEX +: RB_INDEX]  = ix;
  endtask

  task automatic test_reset_state();
    reset = 1'b1; rb_ready = 1'b1; flush = 1'b0; fu_req = 4'hF;
    fu_data_bus = '0; fu_index_bus = '0;
    for (int i = 0; i < FU_NUM; i++) set_fu(i, 32'h1000 + i, 4'(i));
    tick(); tick(); #1;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", cdb_valid); end
    checks++; if (cdb_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", cdb_data); end
    checks++; if (cdb_index !== 4'h0) begin errors++; $display("FAIL rst_index got %h exp 0", cdb_index); end
    checks++; if (cdb_src !== 2'd0) begin errors++; $display("FAIL rst_src got %0d exp 0", cdb_src); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL rst_pending got %0d exp 0", pending); end
    checks++; if (fu_ack !== 4'b0000) begin errors++; $display("FAIL rst_ack got %b exp 0000", fu_ack); end
    fu_req = '0;
    reset = 1'b0;
  endtask

  task automatic test_backpressure();
    tick();
    rb_ready = 1'b1; fu_req = 4'b1010;
    set_fu(1, 32'h1111_1111, 4'd8); set_fu(3, 32'h3333_3333, 4'd9);
    #1;
    checks++; if (fu_ack !== 4'b1010) begin errors++; $display("FAIL bp_fill_ack got %b exp 1010", fu_ack); end
    tick();
    rb_ready = 1'b0;
    set_fu(1, 32'h5555_5555, 4'd10); set_fu(3, 32'h6666_6666, 4'd11);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (fu_ack !== 4'b0000) begin errors++; $display("FAIL bp_ack c%0d got %b exp 0000", c, fu_ack); end
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL bp_valid c%0d got %b exp 0", c, cdb_valid); end
      checks++; if (pending !== 3'd2) begin errors++; $display("FAIL bp_pending c%0d got %0d exp 2", c, pending); end
      tick();
    end
    rb_ready = 1'b1; fu_req = '0;
    #1;
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL bp_last_valid got %b exp 0", cdb_valid); end
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd1) begin errors++; $display("FAIL bp_first got v%b src%0d exp v1 src1", cdb_valid, cdb_src); end
    checks++; if (cdb_data !== 32'h1111_1111 || cdb_index !== 4'd8) begin errors++; $display("FAIL bp_first_data got %h/%0d exp 11111111/8", cdb_data, cdb_index); end
    checks++; if (pending !== 3'd1) begin errors++; $display("FAIL bp_pending1 got %0d exp 1", pending); end
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd3) begin errors++; $display("FAIL bp_second got v%b src%0d exp v1 src3", cdb_valid, cdb_src); end
    checks++; if (cdb_data !== 32'h3333_3333 || cdb_index !== 4'd9) begin errors++; $display("FAIL bp_second_data got %h/%0d exp 33333333/9", cdb_data, cdb_index); end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid got %b exp 0", cdb_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_src [4];
    logic [31:0] exp_dat [4];
    logic [3:0]  exp_idx [4];
    // Pure drain: no refills.
    tick();
    fu_req = 4'hF;
    for (int i = 0; i < FU_NUM; i++) set_fu(i, 32'hA0 + i, 4'(i + 1));
    #1;
    checks++; if (fu_ack !== 4'hF) begin errors++; $display("FAIL rr_ack got %b exp 1111", fu_ack); end
    tick();
    fu_req = '0;
    checks++; if (pending !== 3'd4) begin errors++; $display("FAIL rr_pending4 got %0d exp 4", pending); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'(k)) begin errors++; $display("FAIL rr_src k%0d got v%b src%0d exp v1 src%0d", k, cdb_valid, cdb_src, k); end
      checks++; if (cdb_data !== 32'hA0 + k || cdb_index !== 4'(k + 1)) begin errors++; $display("FAIL rr_data k%0d got %h/%0d exp %h/%0d", k, cdb_data, cdb_index, 32'hA0 + k, k + 1); end
      checks++; if (pending !== 3'(3 - k)) begin errors++; $display("FAIL rr_pending k%0d got %0d exp %0d", k, pending, 3 - k); end
    end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rr_drain_end got %b exp 0", cdb_valid); end
    // All four, then FU0 and FU1 immediately request again.
    tick();
    fu_req = 4'hF;
    for (int i = 0; i < FU_NUM; i++) set_fu(i, 32'hC0 + i, 4'(i + 1));
    #1;
    checks++; if (fu_ack !== 4'hF) begin errors++; $display("FAIL rr2_ack0 got %b exp 1111", fu_ack); end
    tick();
    fu_req = 4'b0011; set_fu(0, 32'hD0, 4'd6); set_fu(1, 32'hD1, 4'd7);
    #1;
    checks++; if (fu_ack !== 4'b0001) begin errors++; $display("FAIL rr2_ack1 got %b exp 0001", fu_ack); end
    tick();
    fu_req = 4'b0010;
    #1;
    checks++; if (fu_ack !== 4'b0010) begin errors++; $display("FAIL rr2_ack2 got %b exp 0010", fu_ack); end
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_data !== 32'hC0) begin errors++; $display("FAIL rr2_b0 got v%b src%0d %h exp v1 src0 c0", cdb_valid, cdb_src, cdb_data); end
    tick();
    fu_req = '0;
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_data !== 32'hC1) begin errors++; $display("FAIL rr2_b1 got v%b src%0d %h exp v1 src1 c1", cdb_valid, cdb_src, cdb_data); end
    exp_src = '{2'd2, 2'd3, 2'd0, 2'd1};
    exp_dat = '{32'hC2, 32'hC3, 32'hD0, 32'hD1};
    exp_idx = '{4'd3, 4'd4, 4'd6, 4'd7};
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (cdb_valid !== 1'b1 || cdb_src !== exp_src[k] || cdb_data !== exp_dat[k] || cdb_index !== exp_idx[k]) begin
        errors++; $display("FAIL rr2_seq k%0d got v%b src%0d %h/%0d exp v1 src%0d %h/%0d", k, cdb_valid, cdb_src, cdb_data, cdb_index, exp_src[k], exp_dat[k], exp_idx[k]);
      end
    end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rr2_end got %b exp 0", cdb_valid); end
  endtask

  task automatic test_single();
    tick();
    rb_ready = 1'b1; fu_req = 4'b0100; set_fu(2, 32'hDEAD_BEEF, 4'd5);
    #1;
    checks++; if (fu_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b exp 0100", fu_ack); end
    tick();
    fu_req = '0;
    checks++; if (cdb_valid !== 1'b0 || pending !== 3'd1) begin errors++; $display("FAIL single_c2 got v%b p%0d exp v0 p1", cdb_valid, pending); end
    tick();
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", cdb_valid); end
    checks++; if (cdb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", cdb_data); end
    checks++; if (cdb_index !== 4'd5 || cdb_src !== 2'd2) begin errors++; $display("FAIL single_idx_src got %0d/%0d exp 5/2", cdb_index, cdb_src); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL single_pending got %0d exp 0", pending); end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_c4 got %b exp 0", cdb_valid); end
  endtask

  task automatic test_flush();
    tick();
    rb_ready = 1'b0; fu_req = 4'b1110;
    set_fu(1, 32'hE1, 4'd1); set_fu(2, 32'hE2, 4'd2); set_fu(3, 32'hE3, 4'd3);
    #1;
    checks++; if (fu_ack !== 4'b1110) begin errors++; $display("FAIL flush_fill_ack got %b exp 1110", fu_ack); end
    tick();
    flush = 1'b1; rb_ready = 1'b1; fu_req = 4'b0011;
    set_fu(0, 32'hE0, 4'd4); set_fu(1, 32'hE5, 4'd5);
    #1;
    checks++; if (fu_ack !== 4'b0000) begin errors++; $display("FAIL flush_ack got %b exp 0000", fu_ack); end
    checks++; if (pending !== 3'd3) begin errors++; $display("FAIL flush_pending3 got %0d exp 3", pending); end
    tick();
    flush = 1'b0; fu_req = '0;
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL flush_pending0 got %0d exp 0", pending); end
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", cdb_valid); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (cdb_valid !== 1'b0 || pending !== 3'd0) begin errors++; $display("FAIL flush_after c%0d got v%b p%0d exp v0 p0", c, cdb_valid, pending); end
    end
  endtask

  task automatic test_null_index();
    tick();
    rb_ready = 1'b0; fu_req = 4'b1000; set_fu(3, 32'h77, 4'd7);
    #1;
    checks++; if (fu_ack !== 4'b1000) begin errors++; $display("FAIL null_fill_ack got %b exp 1000", fu_ack); end
    tick();
    fu_req = 4'b0010; set_fu(1, 32'hBAD, 4'hF);
    #1;
    checks++; if (fu_ack !== 4'b0000) begin errors++; $display("FAIL null_ack_a got %b exp 0000", fu_ack); end
    tick();
    rb_ready = 1'b1;
    #1;
    checks++; if (fu_ack !== 4'b0000) begin errors++; $display("FAIL null_ack_b got %b exp 0000", fu_ack); end
    checks++; if (pending !== 3'd1 || cdb_valid !== 1'b0) begin errors++; $display("FAIL null_pending got p%0d v%b exp p1 v0", pending, cdb_valid); end
    tick();
    fu_req = '0;
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd3 || cdb_data !== 32'h77) begin errors++; $display("FAIL null_fu3 got v%b src%0d %h exp v1 src3 77", cdb_valid, cdb_src, cdb_data); end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL null_pending0 got %0d exp 0", pending); end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL null_nobcast c%0d got %b exp 0", c, cdb_valid); end
    end
  endtask

  task automatic test_reset();
    tick();
    rb_ready = 1'b1; fu_req = 4'hF;
    for (int i = 0; i < FU_NUM; i++) set_fu(i, 32'hF0 + i, 4'(i + 1));
    #1;
    checks++; if (fu_ack !== 4'hF) begin errors++; $display("FAIL rstm_ack got %b exp 1111", fu_ack); end
    tick();
    fu_req = '0;
    checks++; if (pending !== 3'd4) begin errors++; $display("FAIL rstm_pending got %0d exp 4", pending); end
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_data !== 32'hF0) begin errors++; $display("FAIL rstm_pre got v%b src%0d %h exp v1 src0 f0", cdb_valid, cdb_src, cdb_data); end
    fu_req = 4'hF;
    #1;
    checks++; if (fu_ack !== 4'b0011) begin errors++; $display("FAIL rstm_ack2 got %b exp 0011", fu_ack); end
    #1;
    reset = 1'b1;
    #1;
    checks++; if (cdb_valid !== 1'b0 || cdb_data !== 32'h0 || cdb_index !== 4'h0 || cdb_src !== 2'd0) begin
      errors++; $display("FAIL rstm_cdb got v%b %h/%0d src%0d exp all 0", cdb_valid, cdb_data, cdb_index, cdb_src);
    end
    checks++; if (pending !== 3'd0) begin errors++; $display("FAIL rstm_pending0 got %0d exp 0", pending); end
    checks++; if (fu_ack !== 4'b0000) begin errors++; $display("FAIL rstm_ack0 got %b exp 0000", fu_ack); end
    tick();
    reset = 1'b0; fu_req = 4'b1001;
    set_fu(0, 32'h0A, 4'd1); set_fu(3, 32'h0D, 4'd4);
    #1;
    checks++; if (fu_ack !== 4'b1001) begin errors++; $display("FAIL rstm_post_ack got %b exp 1001", fu_ack); end
    tick();
    fu_req = '0;
    checks++; if (pending !== 3'd2) begin errors++; $display("FAIL rstm_post_pending got %0d exp 2", pending); end
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_data !== 32'h0A) begin errors++; $display("FAIL rstm_first got v%b src%0d %h exp v1 src0 0a", cdb_valid, cdb_src, cdb_data); end
    tick();
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd3 || cdb_data !== 32'h0D) begin errors++; $display("FAIL rstm_second got v%b src%0d %h exp v1 src3 0d", cdb_valid, cdb_src, cdb_data); end
    tick();
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rstm_end got %b exp 0", cdb_valid); end
  endtask

  initial begin
    test_reset_state();
    test_backpressure();
    test_round_robin();
    test_single();
    test_flush();
    test_null_index();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
